// File: rtl/nivel2_timer.sv
// Countdown timer stage: keypad BCD MM:SS entry, 1 Hz countdown while the
// magnetron runs, timer_done back to the control stage.
module nivel2_timer #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       clearn,
  input  logic       mag_on,
  input  logic       key_valid,
  input  logic [3:0] key,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       timer_done,
  output logic       expired
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TOP = PW'(TICK_DIV - 1);

  logic [3:0]    so_q, so_d;
  logic [3:0]    st_q, st_d;
  logic [3:0]    mo_q, mo_d;
  logic [3:0]    mt_q, mt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          key_prev_q, key_prev_d;
  logic          done_q, done_d;
  logic          exp_q, exp_d;

  logic key_rise;
  logic is_zero;
  logic tick;
  logic b_so, b_st, b_mo;

  assign key_rise = key_valid & ~key_prev_q;
  assign is_zero  = (so_q == 4'd0) && (st_q == 4'd0) &&
                    (mo_q == 4'd0) && (mt_q == 4'd0);

  always_comb begin
    so_d       = so_q;
    st_d       = st_q;
    mo_d       = mo_q;
    mt_d       = mt_q;
    presc_d    = presc_q;
    key_prev_d = key_valid;
    tick       = 1'b0;
    b_so       = 1'b0;
    b_st       = 1'b0;
    b_mo       = 1'b0;

    if (!clearn) begin
      so_d    = 4'd0;
      st_d    = 4'd0;
      mo_d    = 4'd0;
      mt_d    = 4'd0;
      presc_d = '0;
    end else if (key_rise && !mag_on && key <= 4'd9) begin
      mt_d = mo_q;
      mo_d = st_q;
      st_d = so_q;
      so_d = key;
    end else if (mag_on && !is_zero) begin
      if (presc_q == TOP) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    // Borrow chain; the non-zero guard keeps 00:00 from wrapping.
    if (tick) begin
      b_so = (so_q == 4'd0);
      so_d = b_so ? 4'd9 : so_q - 4'd1;
      if (b_so) begin
        b_st = (st_q == 4'd0);
        st_d = b_st ? 4'd5 : st_q - 4'd1;
      end
      if (b_st) begin
        b_mo = (mo_q == 4'd0);
        mo_d = b_mo ? 4'd9 : mo_q - 4'd1;
      end
      if (b_mo) begin
        mt_d = mt_q - 4'd1;
      end
    end

    done_d = (so_d == 4'd0) && (st_d == 4'd0) &&
             (mo_d == 4'd0) && (mt_d == 4'd0);
    exp_d  = tick && done_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      so_q       <= 4'd0;
      st_q       <= 4'd0;
      mo_q       <= 4'd0;
      mt_q       <= 4'd0;
      presc_q    <= '0;
      key_prev_q <= 1'b0;
      done_q     <= 1'b1;
      exp_q      <= 1'b0;
    end else begin
      so_q       <= so_d;
      st_q       <= st_d;
      mo_q       <= mo_d;
      mt_q       <= mt_d;
      presc_q    <= presc_d;
      key_prev_q <= key_prev_d;
      done_q     <= done_d;
      exp_q      <= exp_d;
    end
  end

  assign sec_ones   = so_q;
  assign sec_tens   = st_q;
  assign min_ones   = mo_q;
  assign min_tens   = mt_q;
  assign timer_done = done_q;
  assign expired    = exp_q;

endmodule

// File: tb/tb_nivel2_timer.sv
// Directed bench for nivel2_timer with TICK_DIV = 4.
// Display is compared as a packed MM:SS hex word.
module tb_nivel2_timer;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       clearn = 1'b1;
  logic       mag_on = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'd0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       timer_done, expired;
  logic [15:0] disp;

  int errors = 0;
  int checks = 0;

  nivel2_timer #(.TICK_DIV(4)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .clearn     (clearn),
    .mag_on     (mag_on),
    .key_valid  (key_valid),
    .key        (key),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .timer_done (timer_done),
    .expired    (expired)
  );

  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  always #5 clock = ~clock;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] k, input int hold);
    key       = k;
    key_valid = 1'b1;
    step(hold);
    key_valid = 1'b0;
    step(1);
  endtask

  task automatic do_reset();
    mag_on    = 1'b0;
    key_valid = 1'b0;
    clearn    = 1'b1;
    resetn    = 1'b0;
    step(2);
    resetn    = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (disp !== 16'h0000) begin
      errors++;
      $display("FAIL reset_disp got %h want 0000", disp);
    end
    checks++;
    if (timer_done !== 1'b1 || expired !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got done=%b exp=%b want 1 0",
               timer_done, expired);
    end
  endtask

  task automatic test_key_entry();
    do_reset();
    key       = 4'd1;
    key_valid = 1'b1;
    step(1);
    checks++;
    if (disp !== 16'h0001) begin
      errors++;
      $display("FAIL key_latency got %h want 0001", disp);
    end
    step(2);
    key_valid = 1'b0;
    step(1);
    press(4'd3, 3);
    press(4'd0, 3);
    checks++;
    if (disp !== 16'h0130) begin
      errors++;
      $display("FAIL key_entry got %h want 0130", disp);
    end
    checks++;
    if (timer_done !== 1'b0) begin
      errors++;
      $display("FAIL key_done got %b want 0", timer_done);
    end
    press(4'd12, 3);
    checks++;
    if (disp !== 16'h0130) begin
      errors++;
      $display("FAIL key_ignore12 got %h want 0130", disp);
    end
  endtask

  task automatic test_count_zero();
    int bad;
    do_reset();
    press(4'd0, 1);
    press(4'd0, 1);
    press(4'd0, 1);
    press(4'd2, 1);
    mag_on = 1'b1;
    step(3);
    checks++;
    if (disp !== 16'h0002) begin
      errors++;
      $display("FAIL cnt_3cyc got %h want 0002", disp);
    end
    step(1);
    checks++;
    if (disp !== 16'h0001) begin
      errors++;
      $display("FAIL cnt_4cyc got %h want 0001", disp);
    end
    step(4);
    checks++;
    if (disp !== 16'h0000 || timer_done !== 1'b1) begin
      errors++;
      $display("FAIL cnt_zero got %h done=%b want 0000 1",
               disp, timer_done);
    end
    checks++;
    if (expired !== 1'b1) begin
      errors++;
      $display("FAIL cnt_expired got %b want 1", expired);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (disp !== 16'h0000 || expired !== 1'b0 ||
          timer_done !== 1'b1)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL cnt_hold_zero got %0d bad cycles want 0", bad);
    end
    mag_on = 1'b0;
  endtask

  task automatic test_borrow();
    do_reset();
    press(4'd1, 1);
    press(4'd0, 1);
    press(4'd0, 1);
    mag_on = 1'b1;
    step(4);
    mag_on = 1'b0;
    checks++;
    if (disp !== 16'h0059 || expired !== 1'b0) begin
      errors++;
      $display("FAIL borrow_0100 got %h exp=%b want 0059 0",
               disp, expired);
    end
    do_reset();
    press(4'd1, 1);
    press(4'd0, 1);
    press(4'd0, 1);
    press(4'd0, 1);
    mag_on = 1'b1;
    step(4);
    mag_on = 1'b0;
    checks++;
    if (disp !== 16'h0959) begin
      errors++;
      $display("FAIL borrow_1000 got %h want 0959", disp);
    end
    do_reset();
    press(4'd7, 1);
    press(4'd0, 1);
    mag_on = 1'b1;
    step(4);
    mag_on = 1'b0;
    checks++;
    if (disp !== 16'h0069) begin
      errors++;
      $display("FAIL borrow_0070 got %h want 0069", disp);
    end
  endtask

  task automatic test_pause_resume();
    do_reset();
    press(4'd5, 1);
    mag_on = 1'b1;
    step(2);
    mag_on = 1'b0;
    step(10);
    mag_on = 1'b1;
    step(1);
    checks++;
    if (disp !== 16'h0005) begin
      errors++;
      $display("FAIL pause_1st got %h want 0005", disp);
    end
    step(1);
    checks++;
    if (disp !== 16'h0004) begin
      errors++;
      $display("FAIL pause_2nd got %h want 0004", disp);
    end
    press(4'd7, 1);
    checks++;
    if (disp !== 16'h0004) begin
      errors++;
      $display("FAIL key_while_on got %h want 0004", disp);
    end
    mag_on = 1'b0;
  endtask

  task automatic test_clear_reset();
    do_reset();
    press(4'd3, 1);
    press(4'd0, 1);
    mag_on = 1'b1;
    step(2);
    clearn = 1'b0;
    step(1);
    clearn = 1'b1;
    checks++;
    if (disp !== 16'h0000 || timer_done !== 1'b1 ||
        expired !== 1'b0) begin
      errors++;
      $display("FAIL clear got %h done=%b exp=%b want 0000 1 0",
               disp, timer_done, expired);
    end
    mag_on = 1'b0;
    press(4'd3, 1);
    press(4'd0, 1);
    mag_on = 1'b1;
    step(3);
    checks++;
    if (disp !== 16'h0030) begin
      errors++;
      $display("FAIL clear_presc3 got %h want 0030", disp);
    end
    step(1);
    checks++;
    if (disp !== 16'h0029) begin
      errors++;
      $display("FAIL clear_presc4 got %h want 0029", disp);
    end
    step(2);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (disp !== 16'h0000 || timer_done !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got %h done=%b want 0000 1",
               disp, timer_done);
    end
    mag_on = 1'b0;
    step(1);
    resetn = 1'b1;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_key_entry();
    test_count_zero();
    test_borrow();
    test_pause_resume();
    test_clear_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
